// File: rtl/clk_select_sequencer_if.sv
// Request handshake and clock-select outputs of clk_select_sequencer.
// master: the configuration/control side issuing switch requests.
// slave : the sequencer itself.
interface clk_select_sequencer_if;

  logic       REQ_VALID;
  logic       REQ_READY;
  logic       REQ_MASTER;
  logic [2:0] REQ_DESIGN;
  logic       MASTER_CLK_SELECT;
  logic [2:0] DESIGN_CLK_SELECT;
  logic       CLK_GATE_EN;
  logic       BUSY;
  logic       DONE;
  logic       ERR;

  modport master (
    output REQ_VALID,
    output REQ_MASTER,
    output REQ_DESIGN,
    input  REQ_READY,
    input  MASTER_CLK_SELECT,
    input  DESIGN_CLK_SELECT,
    input  CLK_GATE_EN,
    input  BUSY,
    input  DONE,
    input  ERR
  );

  modport slave (
    input  REQ_VALID,
    input  REQ_MASTER,
    input  REQ_DESIGN,
    output REQ_READY,
    output MASTER_CLK_SELECT,
    output DESIGN_CLK_SELECT,
    output CLK_GATE_EN,
    output BUSY,
    output DONE,
    output ERR
  );

endinterface

// File: rtl/clk_select_sequencer.sv
// clk_select_sequencer: glitch-safe master/design clock-select switching.
// A request is accepted over a valid/ready handshake. The downstream clock
// is then gated for GATE_WAIT cycles, the captured selects are driven, and
// the clock stays gated for SETTLE_WAIT more cycles before it is released.
// A request equal to the current selects completes in one cycle with no
// gating.
// Optional feature: define CLK_SEQ_LEGAL_CHECK_EN to reject requests whose
// design select exceeds MAX_DESIGN_SEL (ERR pulse, nothing else changes).
// Without the macro every design code is switched and ERR is tied low.
module clk_select_sequencer #(
  parameter int unsigned GATE_WAIT      = 4,
  parameter int unsigned SETTLE_WAIT    = 8,
  parameter int unsigned MAX_DESIGN_SEL = 5
) (
  input  logic                         CLK,
  input  logic                         RESET,
  clk_select_sequencer_if.slave        bus
);

  // Elaboration-time range checks: the 8-bit wait counter must never wrap.
  if (GATE_WAIT < 1 || GATE_WAIT > 255) begin : g_gate_wait_range
    $error("clk_select_sequencer: GATE_WAIT must be in 1..255");
  end
  if (SETTLE_WAIT < 1 || SETTLE_WAIT > 255) begin : g_settle_wait_range
    $error("clk_select_sequencer: SETTLE_WAIT must be in 1..255");
  end
  if (MAX_DESIGN_SEL > 7) begin : g_max_design_range
    $error("clk_select_sequencer: MAX_DESIGN_SEL must be in 0..7");
  end

  localparam logic [7:0] GATE_LAST   = 8'(GATE_WAIT - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_NOOP,
    S_GATE,
    S_SETTLE
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       cap_master_q, cap_master_d;
  logic [2:0] cap_design_q, cap_design_d;
  logic       master_q, master_d;
  logic [2:0] design_q, design_d;
  logic       gate_q, gate_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       accept;
  logic       req_legal;
  logic       req_same;

  assign accept   = bus.REQ_VALID && ready_q;
  assign req_same = (bus.REQ_MASTER == master_q) && (bus.REQ_DESIGN == design_q);

`ifdef CLK_SEQ_LEGAL_CHECK_EN
  localparam logic [2:0] MAX_SEL = 3'(MAX_DESIGN_SEL);
  assign req_legal = (bus.REQ_DESIGN <= MAX_SEL);
`else
  assign req_legal = 1'b1;
`endif

  // Next-state, counter, capture and select-update logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cap_master_d = cap_master_q;
    cap_design_d = cap_design_q;
    master_d     = master_q;
    design_d     = design_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      // NOOP keeps REQ_READY high, so it accepts exactly like IDLE.
      S_IDLE, S_NOOP: begin
        state_d = S_IDLE;
        if (accept) begin
          if (!req_legal) begin
            err_d = 1'b1;
          end else if (req_same) begin
            state_d = S_NOOP;
            done_d  = 1'b1;
          end else begin
            state_d      = S_GATE;
            cap_master_d = bus.REQ_MASTER;
            cap_design_d = bus.REQ_DESIGN;
          end
        end
      end

      S_GATE: begin
        if (cnt_q == GATE_LAST) begin
          state_d  = S_SETTLE;
          master_d = cap_master_q;
          design_d = cap_design_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // Status outputs are registered from the next state so they line up with
  // the state they describe instead of lagging it by a cycle.
  always_comb begin
    busy_d  = (state_d == S_GATE) || (state_d == S_SETTLE);
    gate_d  = !busy_d;
    ready_d = !busy_d;
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cap_master_q <= 1'b0;
      cap_design_q <= '0;
      master_q     <= 1'b0;
      design_q     <= '0;
      gate_q       <= 1'b1;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cap_master_q <= cap_master_d;
      cap_design_q <= cap_design_d;
      master_q     <= master_d;
      design_q     <= design_d;
      gate_q       <= gate_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.REQ_READY         = ready_q;
  assign bus.MASTER_CLK_SELECT = master_q;
  assign bus.DESIGN_CLK_SELECT = design_q;
  assign bus.CLK_GATE_EN       = gate_q;
  assign bus.BUSY              = busy_q;
  assign bus.DONE              = done_q;
  assign bus.ERR               = err_q;

endmodule

// File: tb/tb_clk_select_sequencer.sv
// Testbench for clk_select_sequencer: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against an
// event-timed reference model (accept time + fixed offsets).
module tb_clk_select_sequencer;

  localparam int G    = 4;
  localparam int S    = 8;
  localparam int MAXD = 5;
`ifdef CLK_SEQ_LEGAL_CHECK_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  clk_select_sequencer_if bus ();

  clk_select_sequencer #(
    .GATE_WAIT      (G),
    .SETTLE_WAIT    (S),
    .MAX_DESIGN_SEL (MAXD)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // kind of the last accepted request: 0 none, 1 noop, 2 switch, 3 rejected
  int         kind = 0;
  longint     e = 0, t0 = 0;
  logic       nm = 1'b0;
  logic [2:0] nd = '0;
  logic       vm = 1'b0;
  logic [2:0] vd = '0;
  logic       x_gate = 1'b1, x_ready = 1'b1, x_busy = 1'b0, x_done = 1'b0, x_err = 1'b0;
  logic       m_rst = 1'b1;
  bit         model_ok = 1'b0;

  always @(posedge clk) begin
    longint k;
    bit     acc;
    acc   = bus.REQ_VALID && x_ready && !rst;
    m_rst = rst;
    if (rst) begin
      kind = 0;
      vm   = 1'b0;
      vd   = '0;
    end else if (acc) begin
      t0 = e;
      if (LC && int'(bus.REQ_DESIGN) > MAXD) kind = 3;
      else if (bus.REQ_MASTER == vm && bus.REQ_DESIGN == vd) kind = 1;
      else begin
        kind = 2;
        nm   = bus.REQ_MASTER;
        nd   = bus.REQ_DESIGN;
      end
    end
    // k = 0 describes cycle 1 after the accept edge
    k = e - t0;
    x_gate = 1'b1; x_busy = 1'b0; x_ready = 1'b1; x_done = 1'b0; x_err = 1'b0;
    if (!rst) begin
      case (kind)
        1: x_done = (k == 0);
        3: x_err  = (k == 0);
        2: begin
          if (k < G + S) begin
            x_gate = 1'b0; x_busy = 1'b1; x_ready = 1'b0;
          end
          if (k == G) begin
            vm = nm;
            vd = nd;
          end
          if (k == G + S) x_done = 1'b1;
        end
        default: ;
      endcase
    end
    e++;
    model_ok = 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  logic       pm = 1'b0;
  logic [2:0] pd = '0;
  logic       pg = 1'b1;

  always @(negedge clk) begin
    if (model_ok) begin
      chk("gate",   int'(bus.CLK_GATE_EN),       int'(x_gate));
      chk("ready",  int'(bus.REQ_READY),         int'(x_ready));
      chk("busy",   int'(bus.BUSY),              int'(x_busy));
      chk("done",   int'(bus.DONE),              int'(x_done));
      chk("err",    int'(bus.ERR),               int'(x_err));
      chk("master", int'(bus.MASTER_CLK_SELECT), int'(vm));
      chk("design", int'(bus.DESIGN_CLK_SELECT), int'(vd));
      chk("done_err_excl", int'(bus.DONE & bus.ERR), 0);
      if (!m_rst && (bus.MASTER_CLK_SELECT != pm || bus.DESIGN_CLK_SELECT != pd))
        chk("sel_change_gated", int'({pg, bus.CLK_GATE_EN}), 0);
      pm = bus.MASTER_CLK_SELECT;
      pd = bus.DESIGN_CLK_SELECT;
      pg = bus.CLK_GATE_EN;
    end
  end

  // ---------------- stimulus ----------------
  // Present a request for one edge (accepted when idle), then scramble the
  // request fields so a late capture would be visible.
  task automatic send(input logic m, input logic [2:0] d);
    @(posedge clk); #1;
    bus.REQ_VALID  = 1'b1;
    bus.REQ_MASTER = m;
    bus.REQ_DESIGN = d;
    @(posedge clk); #1;
    bus.REQ_VALID  = 1'b0;
    bus.REQ_MASTER = ~m;
    bus.REQ_DESIGN = ~d;
  endtask

  initial begin
    bus.REQ_VALID  = 1'b0;
    bus.REQ_MASTER = 1'b0;
    bus.REQ_DESIGN = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_gate",  int'(bus.CLK_GATE_EN), 1);
    chk("reset_ready", int'(bus.REQ_READY), 1);
    chk("reset_sel",   int'({bus.MASTER_CLK_SELECT, bus.DESIGN_CLK_SELECT}), 0);

    // full switch to 1/3
    send(1'b1, 3'd3);
    for (int unsigned c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("t1_c1_gate", int'(bus.CLK_GATE_EN), 0);
        chk("t1_c1_ready", int'(bus.REQ_READY), 0);
      end
      if (c == 4) chk("t1_c4_sel", int'({bus.MASTER_CLK_SELECT, bus.DESIGN_CLK_SELECT}), 0);
      if (c == 5) chk("t1_c5_sel", int'({bus.MASTER_CLK_SELECT, bus.DESIGN_CLK_SELECT}), 11);
      if (c == 12) chk("t1_c12_gate", int'(bus.CLK_GATE_EN), 0);
      if (c == 13) begin
        chk("t1_c13_gate", int'(bus.CLK_GATE_EN), 1);
        chk("t1_c13_done", int'(bus.DONE), 1);
        chk("t1_c13_ready", int'(bus.REQ_READY), 1);
      end
    end

    // request equal to current selects
    send(1'b1, 3'd3);
    @(negedge clk);
    chk("noop_done", int'(bus.DONE), 1);
    chk("noop_gate", int'(bus.CLK_GATE_EN), 1);
    chk("noop_busy", int'(bus.BUSY), 0);

    // second request held pending during a sequence
    send(1'b0, 3'd5);
    for (int unsigned r = 1; r <= 17; r++) begin
      @(posedge clk); #1;
      if (r == 2) begin
        bus.REQ_VALID  = 1'b1;
        bus.REQ_MASTER = 1'b1;
        bus.REQ_DESIGN = 3'd6;
      end
      if (r == 13) bus.REQ_VALID = 1'b0;
      @(negedge clk);
      if (r == 12) begin
        chk("t3_done", int'(bus.DONE), 1);
        chk("t3_sel_first", int'(bus.DESIGN_CLK_SELECT), 5);
      end
      if (r == 13) chk("t3_accepted", int'(bus.REQ_READY), 0);
      if (r == 16) chk("t3_sel_before", int'(bus.DESIGN_CLK_SELECT), 5);
      if (r == 17) chk("t3_sel_after", int'({bus.MASTER_CLK_SELECT, bus.DESIGN_CLK_SELECT}), 14);
    end
    repeat (12) @(posedge clk);

    // reset in cycle 6 of a switch
    send(1'b0, 3'd2);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t4_sel",   int'({bus.MASTER_CLK_SELECT, bus.DESIGN_CLK_SELECT}), 0);
    chk("t4_gate",  int'(bus.CLK_GATE_EN), 1);
    chk("t4_ready", int'(bus.REQ_READY), 1);
    chk("t4_done",  int'(bus.DONE), 0);
    repeat (3) @(posedge clk);

    // design code 7: rejected with the legality check, switched without it
    send(1'b1, 3'd7);
    @(negedge clk);
    chk("t5_err",  int'(bus.ERR), LC ? 1 : 0);
    chk("t5_gate", int'(bus.CLK_GATE_EN), LC ? 1 : 0);
    for (int unsigned r = 1; r <= 12; r++) begin
      @(negedge clk);
      if (r == 12) begin
        chk("t5_sel",  int'({bus.MASTER_CLK_SELECT, bus.DESIGN_CLK_SELECT}), LC ? 0 : 15);
        chk("t5_done", int'(bus.DONE), LC ? 0 : 1);
      end
    end

    // randomized traffic
    for (int unsigned i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      rst           = ($urandom_range(0, 249) == 0);
      bus.REQ_VALID = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.REQ_MASTER = vm;
        bus.REQ_DESIGN = vd;
      end else begin
        bus.REQ_MASTER = 1'($urandom_range(0, 1));
        bus.REQ_DESIGN = 3'($urandom_range(0, 7));
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.REQ_VALID = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
